// File: rtl/xrbus_api_responder.sv
// XR-BUS endpoint responder: decodes gateway request frames, runs GET/PUT/PING
// against a local register bank and returns one response frame per request.
module xrbus_api_responder #(
  parameter int          FRAME_W  = 4096,
  parameter logic [7:0]  NODE_ID  = 8'h01,
  parameter int          NUM_REGS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] req_frame,
  input  logic               req_valid,
  output logic               req_ready,
  output logic [FRAME_W-1:0] rsp_frame,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        req_count,
  output logic [15:0]        drop_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t               state_r, state_next_s;
  logic [7:0]           dest_r, src_r, method_r, seq_r;
  logic [31:0]          ep_r, data_r;
  logic                 bcast_r;
  logic [31:0]          regs_r [NUM_REGS];
  logic                 req_ready_r, rsp_valid_r, busy_r;
  logic [FRAME_W-1:0]   rsp_frame_r, rsp_next_s;
  logic [15:0]          req_count_r, drop_count_r;

  logic                 accept_s, dest_hit_s, dest_bcast_s;
  logic [7:0]           idx_s;
  logic                 idx_ok_s, wr_en_s, do_write_s;
  logic [31:0]          rd_data_s, rsp_data_s, status_s;

  // Reserved/status request fields and bits above the frame layout are not consumed.
  logic unused_fields_s;
  assign unused_fields_s = ^{req_frame[159:128], req_frame[95:64]};
  if (FRAME_W > 160) begin : g_upper
    logic unused_upper_s;
    assign unused_upper_s = ^req_frame[FRAME_W-1:160];
  end

  assign accept_s     = req_valid && req_ready_r;
  assign dest_hit_s   = (dest_r == NODE_ID);
  assign dest_bcast_s = (dest_r == 8'hFF);
  assign idx_s        = ep_r[7:0];
  assign idx_ok_s     = ({1'b0, idx_s} < 9'(NUM_REGS));
  assign do_write_s   = (state_r == ST_EXEC) && wr_en_s;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   if (accept_s) state_next_s = ST_DECODE; else state_next_s = ST_IDLE;
      ST_DECODE: if (dest_hit_s || dest_bcast_s) state_next_s = ST_EXEC;
                 else state_next_s = ST_IDLE;
      ST_EXEC:   if (bcast_r) state_next_s = ST_IDLE; else state_next_s = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next_s = ST_IDLE; else state_next_s = ST_RESP;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Register-bank read mux, written as a search so an out-of-range index never indexes the array.
  always_comb begin
    rd_data_s = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_s == 8'(i)) rd_data_s = regs_r[i];
      else rd_data_s = rd_data_s;
    end
  end

  // Method execution; the method is qualified before the index.
  always_comb begin
    wr_en_s    = 1'b0;
    rsp_data_s = 32'h0;
    status_s   = 32'h0000_0405;
    case (method_r)
      8'h01: begin
        if (idx_ok_s) begin rsp_data_s = rd_data_s; status_s = 32'h0000_0200; end
        else status_s = 32'h0000_0404;
      end
      8'h02: begin
        if (idx_ok_s) begin wr_en_s = 1'b1; rsp_data_s = data_r; status_s = 32'h0000_0200; end
        else status_s = 32'h0000_0404;
      end
      8'h03: begin
        rsp_data_s = {24'h0, NODE_ID};
        status_s   = 32'h0000_0200;
      end
      default: status_s = 32'h0000_0405;
    endcase
  end

  // Response frame assembly; unused bits stay zero.
  always_comb begin
    rsp_next_s          = '0;
    rsp_next_s[7:0]     = src_r;
    rsp_next_s[15:8]    = NODE_ID;
    rsp_next_s[23:16]   = method_r | 8'h80;
    rsp_next_s[31:24]   = seq_r;
    rsp_next_s[63:32]   = ep_r;
    rsp_next_s[127:96]  = rsp_data_s;
    rsp_next_s[159:128] = status_s;
  end

  // Control state, request capture, counters and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_frame_r  <= '0;
      dest_r       <= 8'h0;
      src_r        <= 8'h0;
      method_r     <= 8'h0;
      seq_r        <= 8'h0;
      ep_r         <= 32'h0;
      data_r       <= 32'h0;
      bcast_r      <= 1'b0;
      req_count_r  <= 16'h0;
      drop_count_r <= 16'h0;
    end else begin
      state_r     <= state_next_s;
      req_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      rsp_valid_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        dest_r   <= req_frame[7:0];
        src_r    <= req_frame[15:8];
        method_r <= req_frame[23:16];
        seq_r    <= req_frame[31:24];
        ep_r     <= req_frame[63:32];
        data_r   <= req_frame[127:96];
      end
      if (state_r == ST_DECODE) begin
        bcast_r <= !dest_hit_s && dest_bcast_s;
        if (dest_hit_s || dest_bcast_s) begin
          if (req_count_r != 16'hFFFF) req_count_r <= req_count_r + 16'd1;
        end else begin
          if (drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'd1;
        end
      end
      if ((state_r == ST_EXEC) && !bcast_r) rsp_frame_r <= rsp_next_s;
    end
  end

  // Local register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_write_s && (idx_s == 8'(i))) regs_r[i] <= data_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_frame  = rsp_frame_r;
  assign busy       = busy_r;
  assign req_count  = req_count_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_xrbus_api_responder.sv
// Directed bench for xrbus_api_responder: one task per scenario, hand-computed expectations.
module tb_xrbus_api_responder;
  localparam int FW = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] req_frame = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [FW-1:0] rsp_frame;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [15:0]   req_count, drop_count;
  logic          busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  xrbus_api_responder #(.FRAME_W(FW), .NODE_ID(8'h01), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_frame(req_frame), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_frame(rsp_frame), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .req_count(req_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [7:0] d, input logic [7:0] s,
                                       input logic [7:0] m, input logic [7:0] q,
                                       input logic [31:0] ep, input logic [31:0] dat);
    logic [FW-1:0] f;
    f = '0;
    f[7:0] = d; f[15:8] = s; f[23:16] = m; f[31:24] = q;
    f[63:32] = ep; f[127:96] = dat;
    f[4095:4088] = 8'hA5;  // junk above the layout must never reach the response
    return f;
  endfunction

  // Present one frame; returns 1ps after the accepting edge.
  task automatic send(input logic [FW-1:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: req_ready=%0b required 1", req_ready);
    end
    req_frame = f;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it, and let the handshake edge pass.
  task automatic get_rsp(output logic [FW-1:0] r);
    int n;
    n = 0;
    r = '0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin
      chk_cnt++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end else begin
      r = rsp_frame;
      if (rsp_ready) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_valid_busy: got %0b/%0b want 0/0", rsp_valid, busy); else pass_cnt++;
    chk_cnt++; if (rsp_frame !== '0) $display("FAIL reset_rsp_frame: got %h want 0", rsp_frame[159:0]); else pass_cnt++;
    chk_cnt++; if (req_count !== 16'h0 || drop_count !== 16'h0) $display("FAIL reset_counts: got %h/%h want 0/0", req_count, drop_count); else pass_cnt++;
  endtask

  task automatic test_ping_latency();
    send(mk(8'h01, 8'h07, 8'h03, 8'h3C, 32'h0, 32'h0));
    chk_cnt++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL ping_n0: busy/valid %0b/%0b want 1/0", busy, rsp_valid); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL ping_n1_valid: got %0b want 0", rsp_valid); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL ping_n2_valid: got %0b want 1", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_frame[31:0] !== 32'h3C83_0107) $display("FAIL ping_hdr: got %h want 3c830107", rsp_frame[31:0]); else pass_cnt++;
    chk_cnt++; if (rsp_frame[159:96] !== 64'h0000_0200_0000_0001) $display("FAIL ping_status_data: got %h want 0000020000000001", rsp_frame[159:96]); else pass_cnt++;
    chk_cnt++; if (rsp_frame[FW-1:160] !== '0 || rsp_frame[95:32] !== 64'h0) $display("FAIL ping_zero_fields: got %h", rsp_frame[FW-1:4064]); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL ping_n3_idle: ready/valid %0b/%0b want 1/0", req_ready, rsp_valid); else pass_cnt++;
    chk_cnt++; if (req_count !== 16'd1) $display("FAIL ping_req_count: got %0d want 1", req_count); else pass_cnt++;
  endtask

  task automatic test_put_get();
    logic [FW-1:0] r;
    send(mk(8'h01, 8'h07, 8'h02, 8'h10, 32'h5, 32'hDEAD_BEEF)); get_rsp(r);
    chk_cnt++; if (r[23:16] !== 8'h82 || r[127:96] !== 32'hDEAD_BEEF || r[159:128] !== 32'h200) $display("FAIL put_rsp: m=%h d=%h s=%h want 82/deadbeef/200", r[23:16], r[127:96], r[159:128]); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h01, 8'h11, 32'h5, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[23:16] !== 8'h81 || r[127:96] !== 32'hDEAD_BEEF || r[159:128] !== 32'h200) $display("FAIL get_rsp: m=%h d=%h s=%h want 81/deadbeef/200", r[23:16], r[127:96], r[159:128]); else pass_cnt++;
    chk_cnt++; if (r[63:32] !== 32'h5 || r[31:24] !== 8'h11) $display("FAIL get_echo: ep=%h seq=%h want 5/11", r[63:32], r[31:24]); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [FW-1:0] r;
    send(mk(8'h01, 8'h07, 8'h01, 8'h20, 32'h10, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[159:96] !== 64'h0000_0404_0000_0000) $display("FAIL get_range: got %h want 0000040400000000", r[159:96]); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h02, 8'h21, 32'h10, 32'h1234_5678)); get_rsp(r);
    chk_cnt++; if (r[159:96] !== 64'h0000_0404_0000_0000) $display("FAIL put_range: got %h want 0000040400000000", r[159:96]); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h7E, 8'h22, 32'h5, 32'h1111_1111)); get_rsp(r);
    chk_cnt++; if (r[159:96] !== 64'h0000_0405_0000_0000 || r[23:16] !== 8'hFE) $display("FAIL bad_method: got %h m=%h want 0000040500000000/fe", r[159:96], r[23:16]); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h01, 8'h23, 32'h5, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[127:96] !== 32'hDEAD_BEEF) $display("FAIL bad_method_noeffect: got %h want deadbeef", r[127:96]); else pass_cnt++;
  endtask

  task automatic test_drop_broadcast();
    logic [FW-1:0] r;
    logic [15:0] rc;
    bit seen;
    rc = req_count;
    send(mk(8'h02, 8'h07, 8'h01, 8'h30, 32'h5, 32'h0));
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    chk_cnt++; if (seen) $display("FAIL drop_no_rsp: rsp_valid seen=1 want 0"); else pass_cnt++;
    chk_cnt++; if (drop_count !== 16'd1 || req_count !== rc) $display("FAIL drop_counts: drop=%0d req=%0d want 1/%0d", drop_count, req_count, rc); else pass_cnt++;
    send(mk(8'hFF, 8'h07, 8'h02, 8'h31, 32'h2, 32'h1234_5678));
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    chk_cnt++; if (seen) $display("FAIL bcast_no_rsp: rsp_valid seen=1 want 0"); else pass_cnt++;
    chk_cnt++; if (req_count !== rc + 16'd1) $display("FAIL bcast_req_count: got %0d want %0d", req_count, rc + 16'd1); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h01, 8'h32, 32'h2, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[127:96] !== 32'h1234_5678) $display("FAIL bcast_put_effect: got %h want 12345678", r[127:96]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] r;
    bit stable;
    rsp_ready = 1'b0;
    send(mk(8'h01, 8'h09, 8'h01, 8'h40, 32'h5, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[127:96] !== 32'hDEAD_BEEF || r[7:0] !== 8'h09) $display("FAIL bp_rsp: d=%h dest=%h want deadbeef/09", r[127:96], r[7:0]); else pass_cnt++;
    stable = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_frame !== r || req_ready) stable = 0;
    end
    chk_cnt++; if (!stable) $display("FAIL bp_hold: stable=%0b want 1", stable); else pass_cnt++;
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release: valid/ready/busy %0b/%0b/%0b want 0/1/0", rsp_valid, req_ready, busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] r;
    send(mk(8'h01, 8'h07, 8'h02, 8'h50, 32'h3, 32'hAAAA_5555));
    @(posedge clk); #1;  // now in EXEC
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_frame !== '0) $display("FAIL midrst_outputs: valid/busy %0b/%0b want 0/0", rsp_valid, busy); else pass_cnt++;
    chk_cnt++; if (req_count !== 16'h0 || drop_count !== 16'h0) $display("FAIL midrst_counts: got %h/%h want 0/0", req_count, drop_count); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send(mk(8'h01, 8'h07, 8'h01, 8'h51, 32'h3, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[159:96] !== 64'h0000_0200_0000_0000) $display("FAIL midrst_reg3: got %h want 0000020000000000", r[159:96]); else pass_cnt++;
    send(mk(8'h01, 8'h07, 8'h01, 8'h52, 32'h5, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[127:96] !== 32'h0) $display("FAIL midrst_reg5: got %h want 0", r[127:96]); else pass_cnt++;
    send(mk(8'h01, 8'h09, 8'h03, 8'h55, 32'h0, 32'h0)); get_rsp(r);
    chk_cnt++; if (r[31:0] !== 32'h5583_0109 || r[159:96] !== 64'h0000_0200_0000_0001) $display("FAIL midrst_ping: hdr=%h sd=%h want 55830109/0000020000000001", r[31:0], r[159:96]); else pass_cnt++;
    chk_cnt++; if (req_count !== 16'd3) $display("FAIL midrst_req_count: got %0d want 3", req_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ping_latency();
    test_put_get();
    test_errors();
    test_drop_broadcast();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
